// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: output-mux select codes,
// frame sequencer state encodings and parity-type constants.
package uart_tx_pkg;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // data_xor is the reduction XOR of the byte; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register with bit counter; ser_done flags the last data bit.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
      if (gi == DATA_WIDTH - 1) begin : g_msb
        assign shifted[gi] = 1'b0;
      end else begin : g_low
        assign shifted[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  assign ser_done = shift_en && (cnt_reg == CNT_LAST);
  assign ser_data = shift_reg[0];

  always_comb begin
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    if (load) begin
      shift_next = load_data;
      cnt_next   = '0;
    end else if (shift_en) begin
      shift_next = shifted;
      // Wrap to zero on the last bit so the counter is clean for any width.
      cnt_next   = ser_done ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: drives the registered output mux through
// start, LSB-first data, optional parity and stop bits, one bit per CLK.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  tx_state_t state_reg;
  tx_state_t state_next;

  logic par_en_reg;
  logic par_bit_reg;
  logic accept;
  logic shift_en;
  logic ser_bit;
  logic ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .shift_en  (shift_en),
    .load_data (P_DATA),
    .ser_data  (ser_bit),
    .ser_done  (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Configuration is captured only on accept so mid-frame input changes are inert.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else if (accept) begin
      par_en_reg  <= PAR_EN;
      par_bit_reg <= parity_bit(^P_DATA, PAR_TYP);
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    accept     = 1'b0;
    shift_en   = 1'b0;
    mux_sel    = MUX_STOP;
    busy       = 1'b0;
    ser_data   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        accept     = Data_Valid;
        state_next = Data_Valid ? ST_START : ST_IDLE;
      end
      ST_START: begin
        mux_sel    = MUX_START;
        busy       = 1'b1;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        mux_sel    = MUX_DATA;
        busy       = 1'b1;
        ser_data   = ser_bit;
        shift_en   = 1'b1;
        if (ser_done) begin
          state_next = par_en_reg ? ST_PARITY : ST_STOP;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        mux_sel    = MUX_PAR;
        busy       = 1'b1;
        state_next = ST_STOP;
      end
      ST_STOP: begin
        // Back-to-back frames: a request on the stop bit skips idle entirely.
        mux_sel    = MUX_STOP;
        busy       = 1'b1;
        accept     = Data_Valid;
        state_next = Data_Valid ? ST_START : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign par_bit = par_bit_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame shapes, parity, back-to-back, ignore and reset.
module tb_uart_tx_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
  endtask

  // Called while in START; walks the frame and returns while in STOP.
  // At data index disturb_at a one-cycle bogus request with new data is injected.
  task automatic expect_frame(input string name, input logic [7:0] d, input logic pe,
                              input logic exp_par, input int disturb_at);
    chk({name, " start mux"}, {6'd0, mux_sel}, 8'h00);
    chk({name, " start busy"}, {7'd0, busy}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      if (i == disturb_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h00;
        PAR_TYP    = ~PAR_TYP;
        PAR_EN     = ~PAR_EN;
      end else if (i == disturb_at + 1) begin
        Data_Valid = 1'b0;
      end
      tick();
      chk($sformatf("%s data%0d mux", name, i), {6'd0, mux_sel}, 8'h02);
      chk($sformatf("%s data%0d bit", name, i), {7'd0, ser_data}, {7'd0, d[i]});
      chk($sformatf("%s data%0d busy", name, i), {7'd0, busy}, 8'h01);
    end
    if (pe) begin
      tick();
      chk({name, " parity mux"}, {6'd0, mux_sel}, 8'h03);
      chk({name, " parity bit"}, {7'd0, par_bit}, {7'd0, exp_par});
      chk({name, " parity busy"}, {7'd0, busy}, 8'h01);
    end
    tick();
    chk({name, " stop mux"}, {6'd0, mux_sel}, 8'h01);
    chk({name, " stop busy"}, {7'd0, busy}, 8'h01);
    $display("frame %s data=%02h par_en=%0b par_bit=%0b done", name, d, pe, par_bit);
  endtask

  task automatic expect_idle(input string name);
    chk({name, " idle mux"}, {6'd0, mux_sel}, 8'h01);
    chk({name, " idle busy"}, {7'd0, busy}, 8'h00);
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset state, with a request present that must be ignored.
    tick();
    Data_Valid = 1'b1;
    P_DATA     = 8'hFF;
    tick();
    chk("reset mux", {6'd0, mux_sel}, 8'h01);
    chk("reset busy", {7'd0, busy}, 8'h00);
    chk("reset ser", {7'd0, ser_data}, 8'h00);
    chk("reset par", {7'd0, par_bit}, 8'h00);
    Data_Valid = 1'b0;
    RST = 1'b1;
    tick();
    expect_idle("post-reset");

    // 0xA5 even parity
    send(8'hA5, 1'b1, 1'b0); tick(); Data_Valid = 1'b0;
    expect_frame("A5even", 8'hA5, 1'b1, 1'b0, -10);
    tick(); expect_idle("A5even");

    // 0xA5 odd parity
    send(8'hA5, 1'b1, 1'b1); tick(); Data_Valid = 1'b0;
    expect_frame("A5odd", 8'hA5, 1'b1, 1'b1, -10);
    tick(); expect_idle("A5odd");

    // 0xFF even / odd
    send(8'hFF, 1'b1, 1'b0); tick(); Data_Valid = 1'b0;
    expect_frame("FFeven", 8'hFF, 1'b1, 1'b0, -10);
    tick(); expect_idle("FFeven");
    send(8'hFF, 1'b1, 1'b1); tick(); Data_Valid = 1'b0;
    expect_frame("FFodd", 8'hFF, 1'b1, 1'b1, -10);
    tick(); expect_idle("FFodd");

    // 0x3C without parity: 10-cycle frame
    send(8'h3C, 1'b0, 1'b0); tick(); Data_Valid = 1'b0;
    expect_frame("3Cnopar", 8'h3C, 1'b0, 1'b0, -10);
    tick(); expect_idle("3Cnopar");
    tick(); expect_idle("3Cnopar hold");

    // Back-to-back: request during STOP goes straight to START
    send(8'hA5, 1'b1, 1'b0); tick(); Data_Valid = 1'b0;
    expect_frame("b2b-1", 8'hA5, 1'b1, 1'b0, -10);
    send(8'h0F, 1'b0, 1'b0);
    tick(); Data_Valid = 1'b0;
    expect_frame("b2b-2", 8'h0F, 1'b0, 1'b0, -10);
    tick(); expect_idle("b2b");

    // Mid-frame request and data change are dropped
    send(8'hA5, 1'b1, 1'b0); tick(); Data_Valid = 1'b0;
    expect_frame("ignore", 8'hA5, 1'b1, 1'b0, 3);
    tick(); expect_idle("ignore");
    tick(); expect_idle("ignore no-extra");
    tick(); expect_idle("ignore no-extra2");

    // Reset on the third DATA cycle aborts the frame
    send(8'hA5, 1'b1, 1'b1); tick(); Data_Valid = 1'b0;
    tick(); tick(); tick();
    chk("abort pre mux", {6'd0, mux_sel}, 8'h02);
    RST = 1'b0;
    tick();
    chk("abort mux", {6'd0, mux_sel}, 8'h01);
    chk("abort busy", {7'd0, busy}, 8'h00);
    chk("abort ser", {7'd0, ser_data}, 8'h00);
    chk("abort par", {7'd0, par_bit}, 8'h00);
    RST = 1'b1;
    tick(); expect_idle("abort settle");
    send(8'h55, 1'b1, 1'b0); tick(); Data_Valid = 1'b0;
    expect_frame("55even", 8'h55, 1'b1, 1'b0, -10);
    tick(); expect_idle("55even");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel byte with a valid strobe and latches the byte and its parity configuration. It then drives the TX output multiplexer's select, serial-data and parity-bit inputs so the line carries start, data (LSB first), optional parity and stop bits. It runs on the TX bit clock, one CLK cycle per bit, and sits directly upstream of the registered TX output mux.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
CLK  input  1  TX bit clock; one cycle per serial bit
RST  input  1  synchronous, active-low reset
P_DATA  input  DATA_WIDTH  parallel byte to transmit
Data_Valid  input  1  single-cycle or held request; sampled only when accepting
PAR_EN  input  1  1 = insert parity bit; latched at accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; latched at accept
mux_sel  output  2  00 start, 01 stop/idle, 10 serial data, 11 parity
ser_data  output  1  current data bit, LSB first
par_bit  output  1  parity of the latched byte per the latched PAR_TYP
busy  output  1  high while a frame is in progress

Behaviour:
- Reset: CLK and RST are as stated above (reset RST, synchronous, active-low; clock CLK). When RST=0 at a CLK edge: state IDLE, shift register 0, bit counter 0, latched config 0. Outputs while in reset/IDLE: mux_sel=01, ser_data=0, par_bit=0, busy=0.
- Moore outputs are decoded from registered state, shift register and latched config only. No input-to-output combinational path.
- States and outputs:
  - IDLE: mux_sel=01, busy=0.
  - START: mux_sel=00, busy=1.
  - DATA: mux_sel=10, busy=1, ser_data=shift_reg[0].
  - PARITY: mux_sel=11, busy=1.
  - STOP: mux_sel=01, busy=1.
- Accept in IDLE: if Data_Valid=1 at a CLK edge, latch P_DATA into the shift register and latch PAR_EN/PAR_TYP. Compute par_bit = XOR of P_DATA, inverted if PAR_TYP=1, and hold it until the next accept. Next state START.
- START -> DATA after 1 cycle, bit counter cleared.
- DATA: each cycle shift the register right by 1 and increment the counter. After DATA_WIDTH cycles (counter = DATA_WIDTH-1 at the edge), go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY -> STOP after 1 cycle.
- STOP exits after 1 cycle:
  - If Data_Valid=1 at that edge: accept new data exactly as in IDLE and go directly to START. busy stays 1 with no idle gap.
  - Otherwise go to IDLE.
- Frame length in CLK cycles: 1+DATA_WIDTH+1 without parity; 1+DATA_WIDTH+1+1 with parity.
- Data_Valid in START/DATA/PARITY is ignored (dropped, not queued). P_DATA/PAR_EN/PAR_TYP changes mid-frame have no effect.
- Line latency: the downstream mux registers its output, so the TX line lags mux_sel by exactly 1 cycle. This block does not compensate.
- Reset mid-frame: abort immediately. Next cycle is IDLE with reset output values, and no stop bit is sent.
- Illegal/unreachable state encodings: next state IDLE, outputs as IDLE.

Decomposition:
- Shared package uart_tx_pkg holds:
  - mux_sel localparams MUX_START=2'b00, MUX_STOP=2'b01, MUX_DATA=2'b10, MUX_PAR=2'b11 (shared with the output mux).
  - State encodings IDLE/START/DATA/PARITY/STOP.
  - PAR_EVEN=0, PAR_ODD=1.
- One natural sub-module: uart_tx_serializer, containing the DATA_WIDTH shift register, bit counter and done flag.
  - Inputs: load, shift enable, P_DATA.
  - Outputs: ser_data, ser_done.
  - The FSM and parity computation stay in uart_tx_ctrl.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid -> mux_sel sequence 00, 10×8, 11, 01. ser_data during DATA = 1,0,1,0,0,1,0,1. par_bit=0. busy high for exactly 11 cycles.
- Same with PAR_TYP=1, then 0xFF with PAR_TYP=0/1 -> par_bit 1 for 0xA5 odd; 0 then 1 for 0xFF.
- P_DATA=0x3C, PAR_EN=0 -> no 11 state. ser_data 0,0,1,1,1,1,0,0. busy high 10 cycles, then mux_sel=01, busy=0.
- Data_Valid held high with 0x0F during the STOP cycle of a 0xA5 frame -> next cycle mux_sel=00. busy never deasserts. Second frame data bits 1,1,1,1,0,0,0,0.
- Data_Valid pulsed and P_DATA changed to 0x00 during DATA of a 0xA5 frame -> frame unchanged, no extra frame follows, returns to IDLE.
- RST=0 asserted on the 3rd DATA cycle -> next cycle mux_sel=01, busy=0, ser_data=0, par_bit=0. A subsequent Data_Valid with 0x55 produces a clean full frame.
